// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fnd_pkg
// Brief   : Shared constants, FSM encoding and font lookup for the FND scanner
// Revision: 1.0 - initial release
// ============================================================================
package fnd_pkg;

    localparam logic [7:0]  FONT_BLANK = 8'hFF;
    localparam logic [13:0] MAX_VALUE  = 14'd9999;

    // Active-low {dp,g,f,e,d,c,b,a}, digit 9 in the top slot
    localparam logic [9:0][7:0] FONT = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_CONVERT = 1'b1;

    localparam logic [3:0]      DIGIT_OFF = 4'b1111;
    localparam logic [3:0][3:0] DIGIT_EN  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    function automatic logic [7:0] font_of(input logic [3:0] nib);
        logic [7:0] f;
        f = FONT_BLANK;
        if (nib <= 4'd9) begin
            f = FONT[nib];
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_scan_controller_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Captures a saturated 14-bit value and converts it with shift-add-3
// Revision: 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [13:0] i_value,
    output logic        o_busy,
    output logic [15:0] o_bcd,
    output logic        o_done
);

    localparam logic [3:0] LAST_ITER = 4'd13;

    logic [0:0]  state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [14:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] w_adj;
    logic [15:0] w_shift;
    logic [13:0] w_sat;

    assign w_sat = (i_value > MAX_VALUE) ? MAX_VALUE : i_value;

    // Thousands nibble stays <= 4 before the last shift, so it never needs the +3
    always_comb begin
        w_adj[14:12] = bcd_q[14:12];
        for (int k = 0; k < 3; k++) begin
            w_adj[k*4 +: 4] = (bcd_q[k*4 +: 4] >= 4'd5) ? bcd_q[k*4 +: 4] + 4'd3
                                                        : bcd_q[k*4 +: 4];
        end
        w_shift = {w_adj, bin_q[13]};
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CONVERT;
                    bin_d   = w_sat;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_CONVERT: begin
                bin_d = {bin_q[12:0], 1'b0};
                bcd_d = w_shift[14:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_busy = (state_q == ST_CONVERT);
    assign o_done = (state_q == ST_CONVERT) && (cnt_q == LAST_ITER);
    assign o_bcd  = w_shift;

endmodule
`default_nettype wire

// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : fnd_scan_controller
// Brief   : 4-digit common-anode FND scanner with binary-to-BCD front end
// Revision: 1.0 - initial release
// ============================================================================
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SYS_CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ       = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [13:0] i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic [1:0]  o_digitSelect,
    output logic [3:0]  o_digit,
    output logic [7:0]  o_font
);

    localparam int DIV = SYS_CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [1:0]    sel_q;
    logic [3:0]    digit_q;
    logic [7:0]    font_q, font_d;

    logic          w_busy;
    logic          w_done;
    logic [15:0]   w_bcd;
    logic          w_tick;
    logic [15:0]   w_upper;
    logic          w_blank;

    bin2bcd_seq u_bin2bcd (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (i_load),
        .i_value   (i_value),
        .o_busy    (w_busy),
        .o_bcd     (w_bcd),
        .o_done    (w_done)
    );

    assign w_tick  = (presc_q == PRESC_LAST);
    assign presc_d = w_tick ? '0 : presc_q + PW'(1);
    assign idx_d   = w_tick ? idx_q + 2'd1 : idx_q;
    assign disp_d  = w_done ? w_bcd : disp_q;

    // Selected digit sits in the low nibble; the rest are the higher digits
    assign w_upper = disp_q >> {idx_q, 2'b00};
    assign w_blank = (BLANK_LEADING != 0) && (idx_q != 2'd0) && (w_upper == 16'd0);
    assign font_d  = w_blank ? FONT_BLANK : font_of(w_upper[3:0]);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            sel_q   <= '0;
            digit_q <= DIGIT_OFF;
            font_q  <= FONT_BLANK;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            sel_q   <= idx_q;
            digit_q <= DIGIT_EN[idx_q];
            font_q  <= font_d;
        end
    end

    assign o_busy        = w_busy;
    assign o_digitSelect = sel_q;
    assign o_digit       = digit_q;
    assign o_font        = font_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_fnd_scan_controller
// Brief   : Directed self-checking bench for fnd_scan_controller (DIV = 4)
// Revision: 1.0 - initial release
// ============================================================================
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] value;
    logic        load;

    logic        busy_a, busy_b;
    logic [1:0]  sel_a, sel_b;
    logic [3:0]  dig_a, dig_b;
    logic [7:0]  font_a, font_b;

    int errors = 0;
    int checks = 0;

    logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    fnd_scan_controller #(.SYS_CLK_HZ(100), .SCAN_HZ(25), .BLANK_LEADING(1)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value), .i_load(load),
        .o_busy(busy_a), .o_digitSelect(sel_a), .o_digit(dig_a), .o_font(font_a)
    );

    fnd_scan_controller #(.SYS_CLK_HZ(100), .SCAN_HZ(25), .BLANK_LEADING(0)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value), .i_load(load),
        .o_busy(busy_b), .o_digitSelect(sel_b), .o_digit(dig_b), .o_font(font_b)
    );

    // Returns 1 ns after the accepting edge
    task automatic drive_load(input logic [13:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_a && !busy_b) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic collect(output logic [3:0][7:0] fa, output logic [3:0][7:0] fb,
                           output logic [3:0][3:0] da, output bit ok);
        logic [3:0] seen;
        seen = '0;
        fa   = '0;
        fb   = '0;
        da   = '0;
        ok   = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            fa[sel_a]   = font_a;
            da[sel_a]   = dig_a;
            fb[sel_b]   = font_b;
            seen[sel_a] = 1'b1;
            if (&seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int idx;
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dig_a !== 4'b1111) begin
            errors++;
            $display("FAIL reset_digit got %b expected 1111", dig_a);
        end
        checks++;
        if (font_a !== 8'hFF) begin
            errors++;
            $display("FAIL reset_font got %h expected FF", font_a);
        end
        checks++;
        if (busy_a !== 1'b0 || sel_a !== 2'd0) begin
            errors++;
            $display("FAIL reset_busy_sel got busy=%b sel=%0d expected 0/0", busy_a, sel_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            idx = (c - 1) / 4;
            checks++;
            if (dig_a !== pat[idx] || sel_a !== 2'(idx)) begin
                errors++;
                $display("FAIL scan_digit c=%0d got %b sel=%0d expected %b sel=%0d",
                         c, dig_a, sel_a, pat[idx], idx);
            end
            checks++;
            if (font_a !== ((idx == 0) ? 8'hC0 : 8'hFF)) begin
                errors++;
                $display("FAIL scan_font c=%0d got %h expected %h",
                         c, font_a, (idx == 0) ? 8'hC0 : 8'hFF);
            end
        end
    endtask

    task automatic test_load_1234();
        logic [3:0][7:0] fa, fb, exp;
        logic [3:0][3:0] da;
        bit ok;
        int bcnt;
        exp = {8'hF9, 8'hA4, 8'hB0, 8'h99};
        drive_load(14'd1234);
        bcnt = 0;
        while (busy_a && bcnt < 40) begin
            bcnt++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bcnt != 14) begin
            errors++;
            $display("FAIL load1234_busy_cycles got %0d expected 14", bcnt);
        end
        wait_idle(ok);
        collect(fa, fb, da, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL load1234_collect got timeout expected all digits");
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fa[k] !== exp[k] || da[k] !== pat[k]) begin
                errors++;
                $display("FAIL load1234_digit%0d got font=%h en=%b expected font=%h en=%b",
                         k, fa[k], da[k], exp[k], pat[k]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0][7:0] fa, fb;
        logic [3:0][3:0] da;
        bit ok;
        drive_load(14'd12000);
        wait_idle(ok);
        collect(fa, fb, da, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL saturate_wait got timeout expected idle and full scan");
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fa[k] !== 8'h90) begin
                errors++;
                $display("FAIL saturate_digit%0d got %h expected 90", k, fa[k]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [3:0][7:0] fa, fb, exp;
        logic [3:0][3:0] da;
        bit ok;
        int bcnt;
        exp = {8'hFF, 8'hFF, 8'hFF, 8'hF8};
        drive_load(14'd7);
        bcnt = 0;
        while (busy_a && bcnt < 40) begin
            bcnt++;
            load  = (bcnt == 3);
            value = 14'd4321;
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        checks++;
        if (bcnt != 14) begin
            errors++;
            $display("FAIL ignore_busy_cycles got %0d expected 14", bcnt);
        end
        wait_idle(ok);
        collect(fa, fb, da, ok);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fa[k] !== exp[k]) begin
                errors++;
                $display("FAIL ignore_digit%0d got %h expected %h", k, fa[k], exp[k]);
            end
        end
    endtask

    task automatic test_no_blank();
        logic [3:0][7:0] fa, fb, exp_a, exp_b;
        logic [3:0][3:0] da;
        bit ok;
        exp_a = {8'hFF, 8'hFF, 8'h92, 8'hC0};
        exp_b = {8'hC0, 8'hC0, 8'h92, 8'hC0};
        drive_load(14'd50);
        wait_idle(ok);
        collect(fa, fb, da, ok);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fb[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL noblank_digit%0d got %h expected %h", k, fb[k], exp_b[k]);
            end
            checks++;
            if (fa[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL blank50_digit%0d got %h expected %h", k, fa[k], exp_a[k]);
            end
        end
    endtask

    task automatic test_reset_midconv();
        logic [3:0][7:0] fa, fb, exp;
        logic [3:0][3:0] da;
        bit ok;
        drive_load(14'd9999);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || dig_a !== 4'b1111 || font_a !== 8'hFF) begin
            errors++;
            $display("FAIL midreset_async got busy=%b en=%b font=%h expected 0/1111/FF",
                     busy_a, dig_a, font_a);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        collect(fa, fb, da, ok);
        exp = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fa[k] !== exp[k]) begin
                errors++;
                $display("FAIL midreset_zero_digit%0d got %h expected %h", k, fa[k], exp[k]);
            end
        end
        drive_load(14'd42);
        wait_idle(ok);
        collect(fa, fb, da, ok);
        exp = {8'hFF, 8'hFF, 8'h99, 8'hA4};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fa[k] !== exp[k]) begin
                errors++;
                $display("FAIL after_reset42_digit%0d got %h expected %h", k, fa[k], exp[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_1234();
        test_saturate();
        test_busy_ignore();
        test_no_blank();
        test_reset_midconv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
